// File: rtl/id_capture_buffer.sv
//==============================================================================
// Module      : id_capture_buffer
// Description : Samples a multi-nibble ID word on a divided tick, debounces
//               it, and stores each new stable non-zero value nibble-reversed
//               into a DEPTH-deep buffer. The buffer is exposed as a flat bus
//               and an indexed read port, with done/overflow/clear control.
//
//               Optional build macro: ID_CAPTURE_DUP_FILTER_EN
//                 defined   - a capture whose reversed value already exists
//                             in a valid entry is rejected without write,
//                             pulse or overflow
//                 undefined - only back-to-back repeats are suppressed
//
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous active-high reset
//               digit    - live ID word, all-zero means no reading
//               clr      - one-cycle synchronous buffer clear
//               rd_idx   - entry select for rd_data
//               rd_data  - entry[rd_idx], 0 when rd_idx >= DEPTH
//               result   - flat image, entry i at [W*i +: W]
//               count    - number of valid entries
//               wr_pulse - one-cycle strobe per stored entry
//               done     - buffer full
//               overflow - sticky, capture attempted while full
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_capture_buffer #(
    parameter int  NIB        = 5,
    parameter int  DEPTH      = 20,
    parameter int  TICK_DIV   = 6000000,
    parameter int  STABLE_CNT = 2,
    localparam int W          = 4 * NIB,
    localparam int IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         digit,
    input  logic                 clr,
    input  logic [IW-1:0]        rd_idx,
    output logic [W-1:0]         rd_data,
    output logic [W*DEPTH-1:0]   result,
    output logic [CW-1:0]        count,
    output logic                 wr_pulse,
    output logic                 done,
    output logic                 overflow
);

    localparam int          TW       = $clog2(TICK_DIV);
    localparam int          SW       = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CNT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [W-1:0]  last_q, last_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [W-1:0]  last_stored_q, last_stored_d;
    logic [W-1:0]  entry_q [DEPTH];
    logic [W-1:0]  entry_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;

    logic          tick;
    logic          fresh;
    logic          capture;
    logic          dup;
    logic [W-1:0]  digit_rev;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Nibble k of the sample lands in nibble NIB-1-k of the stored entry.
    always_comb begin
        digit_rev = '0;
        for (int k = 0; k < NIB; k++) begin
            digit_rev[4*(NIB-1-k) +: 4] = digit[4*k +: 4];
        end
    end

    always_comb begin
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        last_d        = last_q;
        stab_d        = stab_q;
        last_stored_d = last_stored_q;
        entry_d       = entry_q;
        count_d       = count_q;
        wr_pulse_d    = 1'b0;
        done_d        = done_q;
        overflow_d    = overflow_q;
        fresh         = 1'b0;
        capture       = 1'b0;
        dup           = 1'b0;

        if (clr) begin
            // Clear wins over a coincident capture tick; the held value must
            // re-stabilise before it is stored again.
            last_d        = '0;
            stab_d        = '0;
            last_stored_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i] = '0;
            end
            count_d       = '0;
            done_d        = 1'b0;
            overflow_d    = 1'b0;
        end else if (tick) begin
            if (digit == '0) begin
                last_d = '0;
                stab_d = '0;
            end else if (digit != last_q) begin
                last_d = digit;
                stab_d = SW'(1);
            end else if (stab_q != STAB_MAX) begin
                stab_d = stab_q + 1'b1;
            end

            // A changed value starts a new appearance, so its prior
            // stability count is effectively zero (matters for STABLE_CNT=1).
            fresh   = (digit != last_q) || (stab_q != STAB_MAX);
            capture = (digit != '0) && (stab_d == STAB_MAX) && fresh &&
                      (digit != last_stored_q);

            if (capture) begin
`ifdef ID_CAPTURE_DUP_FILTER_EN
                for (int i = 0; i < DEPTH; i++) begin
                    if ((CW'(i) < count_q) && (entry_q[i] == digit_rev)) begin
                        dup = 1'b1;
                    end
                end
`endif
                if (dup) begin
                    last_stored_d = digit;
                end else if (count_q < DEPTH_C) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (CW'(i) == count_q) begin
                            entry_d[i] = digit_rev;
                        end
                    end
                    count_d       = count_q + 1'b1;
                    last_stored_d = digit;
                    wr_pulse_d    = 1'b1;
                    done_d        = (count_q + 1'b1 == DEPTH_C);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q    <= '0;
            last_q        <= '0;
            stab_q        <= '0;
            last_stored_q <= '0;
            entry_q       <= '{default: '0};
            count_q       <= '0;
            wr_pulse_q    <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            last_q        <= last_d;
            stab_q        <= stab_d;
            last_stored_q <= last_stored_d;
            entry_q       <= entry_d;
            count_q       <= count_d;
            wr_pulse_q    <= wr_pulse_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_idx) < DEPTH) begin
            rd_data = entry_q[rd_idx];
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_flat
            assign result[W*i +: W] = entry_q[i];
        end
    endgenerate

    assign count    = count_q;
    assign wr_pulse = wr_pulse_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_id_capture_buffer.sv
//==============================================================================
// Module      : tb_id_capture_buffer
// Description : Scoreboard bench for id_capture_buffer with TICK_DIV=4,
//               STABLE_CNT=2, NIB=5, DEPTH=4.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_capture_buffer;

    localparam int NIB        = 5;
    localparam int DEPTH      = 4;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 2;
    localparam int W          = 20;
    localparam int IW         = 2;
    localparam int CW         = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        digit;
    logic                clr;
    logic [IW-1:0]       rd_idx;
    logic [W-1:0]        rd_data;
    logic [W*DEPTH-1:0]  result;
    logic [CW-1:0]       count;
    logic                wr_pulse;
    logic                done;
    logic                overflow;

    id_capture_buffer #(
        .NIB        (NIB),
        .DEPTH      (DEPTH),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .digit    (digit),
        .clr      (clr),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .result   (result),
        .count    (count),
        .wr_pulse (wr_pulse),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
        logic          dn;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tb_cnt   = 0;

    // Reference tick phase: the edge after tb_cnt reaches TICK_DIV-1 is a tick.
    always @(posedge clk) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected entry.
    always @(negedge clk) begin
        if (wr_pulse !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr_pulse: got wr_pulse=%b count=%0d expected no write", wr_pulse, count);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_entry", result[W*(int'(mon_e.cnt)-1) +: W], mon_e.data);
                check("wr_count", count, mon_e.cnt);
                check("wr_done",  done,  mon_e.dn);
            end
        end
    end

    task automatic align();
        while (tb_cnt != 0) @(negedge clk);
    endtask

    // Hold a value for exactly n ticks, ending just after the n-th tick.
    task automatic hold(input logic [W-1:0] v, input int n);
        align();
        digit = v;
        repeat (n * TICK_DIV) @(negedge clk);
    endtask

    task automatic clr_pulse();
        align();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d, input int c, input logic dn);
        exp_t e;
        e.data = d;
        e.cnt  = CW'(c);
        e.dn   = dn;
        exp_q.push_back(e);
    endtask

    task automatic check_rd(input int idx, input logic [W-1:0] exp);
        rd_idx = IW'(idx);
        #1;
        check("rd_data", rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        digit  = 20'h12345;
        rd_idx = '0;

        // Reset
        repeat (3) begin
            @(negedge clk);
            check("reset_wr_pulse", wr_pulse, 1'b0);
        end
        rst = 1'b0;
        push(20'h54321, 1, 1'b0);
        @(negedge clk);
        check("post_reset_wr_pulse", wr_pulse, 1'b0);
        check("reset_result",   result,   '0);
        check("reset_count",    count,    '0);
        check("reset_done",     done,     1'b0);
        check("reset_overflow", overflow, 1'b0);

        // Basic capture: 6 ticks total from reset release
        repeat (6 * TICK_DIV - 1) @(negedge clk);
        check("basic_count", count, 3'd1);
        check_rd(0, 20'h54321);

        // Debounce
        clr_pulse();
        hold(20'h11111, 1);
        push(20'h22222, 1, 1'b0);
        hold(20'h22222, 3);
        check("debounce_count", count, 3'd1);
        check_rd(0, 20'h22222);
        push(20'h33333, 2, 1'b0);
        hold(20'h33333, 2);
        hold(20'h00000, 1);
        hold(20'h33333, 2);
        check("gap_repeat_count", count, 3'd2);

        // Fill and overflow
        clr_pulse();
        push(20'h10000, 1, 1'b0); hold(20'h00001, 2);
        push(20'h20000, 2, 1'b0); hold(20'h00002, 2);
        push(20'h30000, 3, 1'b0); hold(20'h00003, 2);
        check("done_before_full", done, 1'b0);
        push(20'h40000, 4, 1'b1); hold(20'h00004, 2);
        check("fill_done",     done,     1'b1);
        check("fill_overflow", overflow, 1'b0);
        check("fill_result",   result,   80'h40000_30000_20000_10000);
        check_rd(1, 20'h20000);
        check_rd(3, 20'h40000);
        hold(20'h00005, 2);
        check("ovf_overflow", overflow, 1'b1);
        check("ovf_count",    count,    3'd4);
        check("ovf_result",   result,   80'h40000_30000_20000_10000);

        // Clear coincident with a capture tick
        clr_pulse();
        check("clr_overflow", overflow, 1'b0);
        push(20'h60000, 1, 1'b0); hold(20'h00006, 2);
        push(20'h70000, 2, 1'b0); hold(20'h00007, 2);
        align();
        digit = 20'h00008;
        repeat (TICK_DIV) @(negedge clk);
        repeat (TICK_DIV - 1) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_tick_count",    count,    3'd0);
        check("clr_tick_result",   result,   '0);
        check("clr_tick_done",     done,     1'b0);
        check("clr_tick_wr_pulse", wr_pulse, 1'b0);
        push(20'h80000, 1, 1'b0);
        repeat (2 * TICK_DIV) @(negedge clk);
        check("recapture_count", count, 3'd1);
        check_rd(0, 20'h80000);

        // Duplicate filter
        clr_pulse();
        push(20'hA0000, 1, 1'b0); hold(20'h0000A, 2);
        push(20'hB0000, 2, 1'b0); hold(20'h0000B, 2);
`ifdef ID_CAPTURE_DUP_FILTER_EN
        hold(20'h0000A, 2);
        check("dup_count", count, 3'd2);
        check("dup_overflow", overflow, 1'b0);
`else
        push(20'hA0000, 3, 1'b0); hold(20'h0000A, 2);
        check("dup_count", count, 3'd3);
        check_rd(2, 20'hA0000);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
